// File: rtl/pc_sequencer.sv
// Program counter sequencer: picks the next fetch address each cycle from
// sequential fetch, taken branch, exception vector or hold. It also runs the
// post-redirect pipeline flush and a stall watchdog that raises an exception
// when a stall lasts too long.
module pc_sequencer #(
   parameter int unsigned      WIDTH        = 16,
   parameter int unsigned      INC          = 2,
   parameter logic [WIDTH-1:0] EXC_VECTOR   = 16'h0040,
   parameter int unsigned      FLUSH_CYCLES = 2,
   parameter int unsigned      MAX_STALL    = 15
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] pc_current,
   input  logic             stall_req,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] branch_target,
   input  logic             exc_req,
   input  logic             halt_req,
   input  logic             resume,
   output logic [WIDTH-1:0] pc_new_address,
   output logic             pc_stop,
   output logic             flush,
   output logic             halted,
   output logic [WIDTH-1:0] epc,
   output logic [1:0]       exc_cause
);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_STALL = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam logic [1:0] ST_HALT  = 2'd3;

   localparam logic [1:0] CAUSE_EXT  = 2'd1;
   localparam logic [1:0] CAUSE_WDOG = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [2:0]       flush_cnt_q, flush_cnt_d;
   logic [7:0]       stall_cnt_q, stall_cnt_d;
   logic [WIDTH-1:0] epc_q, epc_d;
   logic [1:0]       cause_q, cause_d;
   logic             flush_q, halted_q;

   logic [WIDTH-1:0] seq_addr;
   logic             take_exc, take_wdog, take_halt, take_branch, take_stall, take_seq;

   assign seq_addr = pc_current + WIDTH'(INC);

   // Decide which single action wins this cycle for the current state.
   always_comb begin
      take_exc    = 1'b0;
      take_wdog   = 1'b0;
      take_halt   = 1'b0;
      take_branch = 1'b0;
      take_stall  = 1'b0;
      take_seq    = 1'b0;
      case (state_q)
         ST_RUN, ST_STALL: begin
            if (exc_req) begin
               take_exc = 1'b1;
            end else if (halt_req) begin
               take_halt = 1'b1;
            end else if (branch_taken) begin
               take_branch = 1'b1;
            end else if (stall_req) begin
               // The watchdog only fires when a stall would otherwise win.
               if (stall_cnt_q == 8'(MAX_STALL)) take_wdog = 1'b1;
               else take_stall = 1'b1;
            end else begin
               take_seq = 1'b1;
            end
         end
         ST_FLUSH: begin
            // Branch/halt/stall come from killed instructions during a flush.
            if (exc_req) take_exc = 1'b1;
            else take_seq = 1'b1;
         end
         default: begin
            if (resume) take_seq = 1'b1;
         end
      endcase
   end

   // Fetch control to the program counter; forced to hold at zero in reset.
   always_comb begin
      pc_stop        = 1'b1;
      pc_new_address = pc_current;
      if (take_exc || take_wdog) begin
         pc_stop        = 1'b0;
         pc_new_address = EXC_VECTOR;
      end else if (take_branch) begin
         pc_stop        = 1'b0;
         pc_new_address = branch_target;
      end else if (take_seq) begin
         pc_stop        = 1'b0;
         pc_new_address = seq_addr;
      end
      if (reset) begin
         pc_stop        = 1'b1;
         pc_new_address = '0;
      end
   end

   // Next-state values for the FSM, counters and exception capture.
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      stall_cnt_d = stall_cnt_q;
      epc_d       = epc_q;
      cause_d     = cause_q;
      if (take_exc || take_wdog) begin
         state_d     = ST_FLUSH;
         flush_cnt_d = 3'(FLUSH_CYCLES);
         stall_cnt_d = '0;
         epc_d       = pc_current;
         cause_d     = take_exc ? CAUSE_EXT : CAUSE_WDOG;
      end else if (take_halt) begin
         state_d     = ST_HALT;
         stall_cnt_d = '0;
      end else if (take_branch) begin
         state_d     = ST_FLUSH;
         flush_cnt_d = 3'(FLUSH_CYCLES);
         stall_cnt_d = '0;
      end else if (take_stall) begin
         state_d     = ST_STALL;
         stall_cnt_d = stall_cnt_q + 8'd1;
      end else if (take_seq) begin
         if (state_q == ST_FLUSH) begin
            if (flush_cnt_q <= 3'd1) begin
               state_d     = ST_RUN;
               flush_cnt_d = '0;
            end else begin
               flush_cnt_d = flush_cnt_q - 3'd1;
            end
         end else begin
            state_d     = ST_RUN;
            stall_cnt_d = '0;
         end
      end
   end

   // State registers; flush/halted track the state being entered.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_RUN;
         flush_cnt_q <= '0;
         stall_cnt_q <= '0;
         epc_q       <= '0;
         cause_q     <= '0;
         flush_q     <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         epc_q       <= epc_d;
         cause_q     <= cause_d;
         flush_q     <= (state_d == ST_FLUSH);
         halted_q    <= (state_d == ST_HALT);
      end
   end

   assign flush     = flush_q;
   assign halted    = halted_q;
   assign epc       = epc_q;
   assign exc_cause = cause_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_pc_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] pc_current = '0;
   logic        stall_req = 1'b0;
   logic        branch_taken = 1'b0;
   logic [15:0] branch_target = '0;
   logic        exc_req = 1'b0;
   logic        halt_req = 1'b0;
   logic        resume = 1'b0;
   logic [15:0] pc_new_address;
   logic        pc_stop;
   logic        flush;
   logic        halted;
   logic [15:0] epc;
   logic [1:0]  exc_cause;

   pc_sequencer dut (
      .clock         (clock),
      .reset         (reset),
      .pc_current    (pc_current),
      .stall_req     (stall_req),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .exc_req       (exc_req),
      .halt_req      (halt_req),
      .resume        (resume),
      .pc_new_address(pc_new_address),
      .pc_stop       (pc_stop),
      .flush         (flush),
      .halted        (halted),
      .epc           (epc),
      .exc_cause     (exc_cause)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // Reference model: what the machine is doing, in plain terms.
   localparam int MODE_RUN = 0, MODE_STALL = 1, MODE_FLUSH = 2, MODE_HALT = 3;
   localparam int EV_EXC = 0, EV_WDOG = 1, EV_HALT = 2, EV_BR = 3, EV_STALL = 4,
                  EV_SEQ = 5, EV_HOLD = 6;
   int          m_mode;
   int          m_flush_left;
   int          m_stalled;     // consecutive stall cycles already served
   logic [15:0] m_epc;
   logic [1:0]  m_cause;
   logic [15:0] obs_addr;
   logic        obs_stop;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode       = MODE_RUN;
      m_flush_left = 0;
      m_stalled    = 0;
      m_epc        = '0;
      m_cause      = '0;
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      #1;
      check("rst_stop", 32'(pc_stop), 32'd1);
      check("rst_addr", 32'(pc_new_address), 32'd0);
      check("rst_flush", 32'(flush), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_epc", 32'(epc), 32'd0);
      check("rst_cause", 32'(exc_cause), 32'd0);
      repeat (cycles) @(posedge clock);
      #1;
      check("rst_hold_stop", 32'(pc_stop), 32'd1);
      check("rst_hold_epc", 32'(epc), 32'd0);
      reset = 1'b0;
      model_reset();
   endtask

   // One clock cycle: drive, check fetch control, clock, check registers.
   task automatic step(input logic [15:0] pc, input bit st, input bit br, input logic [15:0] bt,
                       input bit ex, input bit ht, input bit rs);
      int          ev;
      logic [15:0] exp_addr;
      logic        exp_stop;
      pc_current    = pc;
      stall_req     = st;
      branch_taken  = br;
      branch_target = bt;
      exc_req       = ex;
      halt_req      = ht;
      resume        = rs;
      #1;
      if (m_mode == MODE_RUN || m_mode == MODE_STALL) begin
         if (ex) ev = EV_EXC;
         else if (ht) ev = EV_HALT;
         else if (br) ev = EV_BR;
         else if (st) ev = (m_stalled == 15) ? EV_WDOG : EV_STALL;
         else ev = EV_SEQ;
      end else if (m_mode == MODE_FLUSH) begin
         ev = ex ? EV_EXC : EV_SEQ;
      end else begin
         ev = rs ? EV_SEQ : EV_HOLD;
      end
      case (ev)
         EV_EXC, EV_WDOG: begin exp_addr = 16'h0040;   exp_stop = 1'b0; end
         EV_BR:           begin exp_addr = bt;         exp_stop = 1'b0; end
         EV_SEQ:          begin exp_addr = pc + 16'd2; exp_stop = 1'b0; end
         default:         begin exp_addr = pc;         exp_stop = 1'b1; end
      endcase
      obs_addr = pc_new_address;
      obs_stop = pc_stop;
      check("pc_new_address", 32'(obs_addr), 32'(exp_addr));
      check("pc_stop", 32'(obs_stop), 32'(exp_stop));
      @(posedge clock);
      case (ev)
         EV_EXC, EV_WDOG: begin
            m_epc        = pc;
            m_cause      = (ev == EV_EXC) ? 2'd1 : 2'd2;
            m_mode       = MODE_FLUSH;
            m_flush_left = 2;
            m_stalled    = 0;
         end
         EV_HALT: begin m_mode = MODE_HALT; m_stalled = 0; end
         EV_BR:   begin m_mode = MODE_FLUSH; m_flush_left = 2; m_stalled = 0; end
         EV_STALL: begin m_mode = MODE_STALL; m_stalled++; end
         EV_SEQ: begin
            if (m_mode == MODE_FLUSH) begin
               m_flush_left--;
               if (m_flush_left == 0) m_mode = MODE_RUN;
            end else begin
               m_mode    = MODE_RUN;
               m_stalled = 0;
            end
         end
         default: ;
      endcase
      #1;
      check("flush", 32'(flush), 32'(m_mode == MODE_FLUSH));
      check("halted", 32'(halted), 32'(m_mode == MODE_HALT));
      check("epc", 32'(epc), 32'(m_epc));
      check("exc_cause", 32'(exc_cause), 32'(m_cause));
   endtask

   initial begin
      int flush_cycles;
      model_reset();
      @(posedge clock);
      #1;
      do_reset(2);

      // Plain sequential fetch after reset.
      step(16'h1110, 0, 0, 16'h0, 0, 0, 0);
      check("seq_1110", 32'(obs_addr), 32'h1112);

      // Short stall then release.
      for (int i = 0; i < 3; i++) begin
         step(16'h0200, 1, 0, 16'h0, 0, 0, 0);
         check("stall3_stop", 32'(obs_stop), 32'd1);
      end
      step(16'h0200, 0, 0, 16'h0, 0, 0, 0);
      check("stall_release", 32'(obs_addr), 32'h0202);

      // Branch beats a simultaneous stall; branch during flush ignored.
      step(16'h0210, 1, 1, 16'habcd, 0, 0, 0);
      check("branch_addr", 32'(obs_addr), 32'habcd);
      flush_cycles = 32'(flush);
      step(16'habcd, 0, 1, 16'h1234, 0, 0, 0);
      check("flush_branch_ign", 32'(obs_addr), 32'habcf);
      flush_cycles += 32'(flush);
      step(16'habcf, 0, 0, 16'h0, 0, 0, 0);
      flush_cycles += 32'(flush);
      check("flush_len_branch", 32'(flush_cycles), 32'd2);

      // External exception.
      step(16'h0300, 0, 0, 16'h0, 1, 0, 0);
      check("exc_vec", 32'(obs_addr), 32'h0040);
      check("exc_epc", 32'(epc), 32'h0300);
      check("exc_cause1", 32'(exc_cause), 32'd1);
      repeat (3) step(16'h0040, 0, 0, 16'h0, 0, 0, 0);

      // Stall watchdog.
      for (int i = 0; i < 20; i++) begin
         step(16'h0500, 1, 0, 16'h0, 0, 0, 0);
         if (i < 15) check("wdog_hold", 32'(obs_stop), 32'd1);
         if (i == 15) check("wdog_vec", 32'(obs_addr), 32'h0040);
      end
      check("wdog_cause", 32'(exc_cause), 32'd2);
      check("wdog_epc", 32'(epc), 32'h0500);
      repeat (3) step(16'h0044, 0, 0, 16'h0, 0, 0, 0);

      // Halt, ignored requests, resume.
      step(16'h0600, 0, 0, 16'h0, 0, 1, 0);
      step(16'h0600, 0, 1, 16'h0700, 1, 0, 0);
      check("halt_ignore", 32'(obs_stop), 32'd1);
      check("halt_stays", 32'(halted), 32'd1);
      step(16'h0600, 0, 0, 16'h0, 0, 0, 1);
      check("resume_addr", 32'(obs_addr), 32'h0602);
      step(16'hFFFE, 0, 0, 16'h0, 0, 0, 0);
      check("wrap", 32'(obs_addr), 32'h0000);

      // Random traffic, with stall-heavy phases and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         logic [15:0] pc;
         bit heavy;
         heavy = ((i / 200) % 3) == 1;
         pc = ($urandom_range(0, 15) == 0) ? 16'hFFFE : 16'($urandom);
         if ($urandom_range(0, 299) == 0) do_reset(1);
         step(pc,
              heavy ? ($urandom_range(0, 99) < 97) : ($urandom_range(0, 99) < 40),
              $urandom_range(0, 99) < (heavy ? 1 : 10),
              16'($urandom),
              $urandom_range(0, 99) < (heavy ? 1 : 3),
              $urandom_range(0, 99) < (heavy ? 1 : 3),
              $urandom_range(0, 99) < 20);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
